// File: rtl/apb_multi_timer.sv
// NUM_CH-channel APB3 down-counter timer: per-channel load, power-of-two prescaler,
// periodic/one-shot mode and maskable interrupt, with global masked/raw status registers.

module apb_multi_timer_ch #(
  parameter int WIDTH = 32
) (
  input  logic             PCLK,
  input  logic             PRESET,
  input  logic             wr_load,
  input  logic             wr_ctrl,
  input  logic             wr_ris,
  input  logic [WIDTH-1:0] wdata_val,
  input  logic [3:0]       wdata_pre,
  input  logic [2:0]       wdata_ctl,
  output logic [WIDTH-1:0] load,
  output logic [WIDTH-1:0] value,
  output logic             en,
  output logic             inten,
  output logic             oneshot,
  output logic [3:0]       pre,
  output logic             raw_int
);

  logic [14:0] pcnt;
  logic [14:0] pre_mask;
  logic        tick_raw;
  logic        tick;
  logic        zero_tick;

  // 15-bit arithmetic makes PRE=15 wrap to a full 0x7FFF mask.
  assign pre_mask  = (15'd1 << pre) - 15'd1;
  assign tick_raw  = en & (pcnt == pre_mask);
  // A CTRL write that clears EN swallows a coincident tick.
  assign tick      = tick_raw & ~(wr_ctrl & ~wdata_ctl[0]);
  assign zero_tick = tick & (value == '0);

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      load    <= '0;
      value   <= '0;
      en      <= 1'b0;
      inten   <= 1'b0;
      oneshot <= 1'b0;
      pre     <= '0;
      raw_int <= 1'b0;
      pcnt    <= '0;
    end else begin
      if (wr_load) load <= wdata_val;

      if (wr_load || !en || tick_raw) pcnt <= '0;
      else                            pcnt <= pcnt + 15'd1;

      if (wr_load)                value <= wdata_val;
      else if (tick) begin
        if (value != '0)          value <= value - 1'b1;
        else if (!oneshot)        value <= load;
      end

      if (wr_ctrl) begin
        en      <= wdata_ctl[0];
        inten   <= wdata_ctl[1];
        oneshot <= wdata_ctl[2];
        pre     <= wdata_pre;
      end else if (zero_tick && oneshot) begin
        en      <= 1'b0;
      end

      // Setting on a zero tick wins over a concurrent clear.
      if (zero_tick)   raw_int <= 1'b1;
      else if (wr_ris) raw_int <= 1'b0;
    end
  end

endmodule

module apb_multi_timer #(
  parameter int NUM_CH     = 4,
  parameter int WIDTH      = 32,
  parameter bit INTACTIVEH = 1'b1
) (
  input  logic              PCLK,
  input  logic              PRESET,
  input  logic              PSEL,
  input  logic              PENABLE,
  input  logic              PWRITE,
  input  logic [7:2]        PADDR,
  input  logic [31:0]       PWDATA,
  output logic [31:0]       PRDATA,
  output logic              PREADY,
  output logic              PSLVERR,
  output logic [NUM_CH-1:0] TIMINT,
  output logic              TIMINT_ANY
);

  logic [NUM_CH-1:0][WIDTH-1:0] load_q;
  logic [NUM_CH-1:0][WIDTH-1:0] value_q;
  logic [NUM_CH-1:0][3:0]       pre_q;
  logic [NUM_CH-1:0]            en_q;
  logic [NUM_CH-1:0]            inten_q;
  logic [NUM_CH-1:0]            oneshot_q;
  logic [NUM_CH-1:0]            raw_q;
  logic [NUM_CH-1:0]            mis;
  logic                         wr_en;
  logic [2:0]                   ch_sel;
  logic [1:0]                   reg_sel;
  logic [31:0]                  rdata;

  assign wr_en   = PSEL & PENABLE & PWRITE;
  assign ch_sel  = PADDR[6:4];
  assign reg_sel = PADDR[3:2];

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    logic ch_wr;
    assign ch_wr = wr_en & ~PADDR[7] & (ch_sel == 3'(g));

    apb_multi_timer_ch #(.WIDTH(WIDTH)) u_ch (
      .PCLK      (PCLK),
      .PRESET    (PRESET),
      .wr_load   (ch_wr & (reg_sel == 2'd0)),
      .wr_ctrl   (ch_wr & (reg_sel == 2'd2)),
      .wr_ris    (ch_wr & (reg_sel == 2'd3)),
      .wdata_val (PWDATA[WIDTH-1:0]),
      .wdata_pre (PWDATA[11:8]),
      .wdata_ctl (PWDATA[2:0]),
      .load      (load_q[g]),
      .value     (value_q[g]),
      .en        (en_q[g]),
      .inten     (inten_q[g]),
      .oneshot   (oneshot_q[g]),
      .pre       (pre_q[g]),
      .raw_int   (raw_q[g])
    );
  end

  assign mis = raw_q & inten_q;

  always_comb begin
    rdata = '0;
    if (PSEL && !PWRITE) begin
      if (PADDR[7]) begin
        case (PADDR[6:2])
          5'd0:    rdata = 32'(mis);
          5'd1:    rdata = 32'(raw_q);
          default: rdata = '0;
        endcase
      end else begin
        for (int i = 0; i < NUM_CH; i++) begin
          if (ch_sel == 3'(i)) begin
            case (reg_sel)
              2'd0:    rdata = 32'(load_q[i]);
              2'd1:    rdata = 32'(value_q[i]);
              2'd2:    rdata = {20'b0, pre_q[i], 5'b0, oneshot_q[i], inten_q[i], en_q[i]};
              default: rdata = {31'b0, raw_q[i]};
            endcase
          end
        end
      end
    end
  end

  assign PRDATA     = rdata;
  assign PREADY     = 1'b1;
  assign PSLVERR    = 1'b0;
  assign TIMINT     = INTACTIVEH ? mis : ~mis;
  assign TIMINT_ANY = INTACTIVEH ? (|mis) : ~(|mis);

endmodule

// File: tb/tb_apb_multi_timer.sv
// Bench for apb_multi_timer: a 4ch/32b active-high instance and a 2ch/16b active-low
// instance share the APB bus; reads go through an expected-value queue.

module tb_apb_multi_timer;

  logic        PCLK = 1'b0;
  logic        rst1 = 1'b1, rst2 = 1'b1;
  logic        sel1 = 1'b0, sel2 = 1'b0;
  logic        PENABLE = 1'b0, PWRITE = 1'b0;
  logic [7:2]  PADDR = '0;
  logic [31:0] PWDATA = '0;
  logic [31:0] prdata1, prdata2;
  logic        pready1, pready2, pslverr1, pslverr2;
  logic [3:0]  timint1;
  logic [1:0]  timint2;
  logic        any1, any2;

  always #5 PCLK = ~PCLK;

  int cyc = 0;
  always @(posedge PCLK) cyc <= cyc + 1;

  apb_multi_timer #(.NUM_CH(4), .WIDTH(32), .INTACTIVEH(1'b1)) u_dut1 (
    .PCLK(PCLK), .PRESET(rst1), .PSEL(sel1), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(prdata1), .PREADY(pready1),
    .PSLVERR(pslverr1), .TIMINT(timint1), .TIMINT_ANY(any1));

  apb_multi_timer #(.NUM_CH(2), .WIDTH(16), .INTACTIVEH(1'b0)) u_dut2 (
    .PCLK(PCLK), .PRESET(rst2), .PSEL(sel2), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(prdata2), .PREADY(pready2),
    .PSLVERR(pslverr2), .TIMINT(timint2), .TIMINT_ANY(any2));

  int n_chk = 0;
  int n_fail = 0;

  typedef struct { string nm; logic [31:0] exp; } sb_t;
  typedef struct { bit d2; bit wr; logic [7:0] a; logic [31:0] d; } vec_t;
  sb_t  sb[$];
  vec_t tbl[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  // Write whose access phase ends at the posedge numbered t; call at a negedge.
  task automatic wr_at(input bit d2, input logic [7:0] a, input logic [31:0] d, input int t);
    while (cyc < t - 2) @(negedge PCLK);
    sel1 = !d2; sel2 = d2; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = a[7:2]; PWDATA = d;
    @(negedge PCLK); PENABLE = 1'b1;
    @(negedge PCLK); sel1 = 1'b0; sel2 = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
  endtask

  task automatic wr(input bit d2, input logic [7:0] a, input logic [31:0] d);
    wr_at(d2, a, d, cyc + 2);
  endtask

  task automatic rd(input bit d2, input logic [7:0] a, input logic [31:0] exp, input string nm);
    sb_t e;
    sb.push_back('{nm, exp});
    sel1 = !d2; sel2 = d2; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = a[7:2];
    @(negedge PCLK); PENABLE = 1'b1;
    #1;
    e = sb.pop_front();
    chk(e.nm, d2 ? prdata2 : prdata1, e.exp);
    @(negedge PCLK); sel1 = 1'b0; sel2 = 1'b0; PENABLE = 1'b0;
  endtask

  // Cycle number at which TIMINT[ch] of the 4-channel instance is first seen high; -1 on timeout.
  task automatic wait_hi(input int ch, input int lim, output int at);
    at = -1;
    for (int i = 0; i < lim; i++) begin
      @(negedge PCLK);
      if (timint1[ch[1:0]]) begin
        at = cyc;
        break;
      end
    end
  endtask

  task automatic add(input bit d2, input bit w, input logic [7:0] a, input logic [31:0] d);
    tbl.push_back('{d2, w, a, d});
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, limit 1000000 ns");
    $fatal(1);
  end

  initial begin
    int k, r1, r2, cnt, L;

    // Register map and decode vectors; for reads d is the expected PRDATA.
    add(0, 0, 8'h00, 32'h0);        add(0, 0, 8'h04, 32'h0);
    add(0, 0, 8'h08, 32'h0);        add(0, 0, 8'h0C, 32'h0);
    add(0, 0, 8'h80, 32'h0);        add(0, 0, 8'h84, 32'h0);
    add(0, 1, 8'h30, 32'h12345678); add(0, 0, 8'h30, 32'h12345678);
    add(0, 0, 8'h34, 32'h12345678);
    add(0, 1, 8'h38, 32'hFFFFF2F6); add(0, 0, 8'h38, 32'h00000206);
    add(0, 1, 8'h38, 32'h0);        add(0, 0, 8'h38, 32'h0);
    add(0, 1, 8'h50, 32'h0000DEAD); add(0, 0, 8'h50, 32'h0);
    add(0, 0, 8'h88, 32'h0);
    add(1, 0, 8'h30, 32'h0);        add(1, 1, 8'h30, 32'h55);
    add(1, 0, 8'h30, 32'h0);        add(1, 0, 8'h40, 32'h0);
    add(1, 1, 8'h10, 32'hFFFFFFFF); add(1, 0, 8'h10, 32'h0000FFFF);
    add(1, 0, 8'h14, 32'h0000FFFF); add(1, 0, 8'h88, 32'h0);

    repeat (3) @(negedge PCLK);
    rst1 = 1'b0; rst2 = 1'b0;
    @(negedge PCLK);
    chk("reset timint1", 32'(timint1), 32'h0);
    chk("reset any1", 32'(any1), 32'h0);
    chk("reset timint2 (active-low)", 32'(timint2), 32'h3);
    chk("reset any2 (active-low)", 32'(any2), 32'h1);
    chk("idle prdata", prdata1, 32'h0);

    for (int i = 0; i < tbl.size(); i++) begin
      if (tbl[i].wr) wr(tbl[i].d2, tbl[i].a, tbl[i].d);
      else rd(tbl[i].d2, tbl[i].a, tbl[i].d, $sformatf("tbl[%0d] dut%0d rd %h", i, tbl[i].d2 ? 2 : 1, tbl[i].a));
    end

    // Periodic ch0: LOAD=3, PRE=0 -> interrupt every 4 cycles.
    wr(0, 8'h00, 32'd3);
    wr(0, 8'h08, 32'h3);
    k = cyc;
    wait_hi(0, 20, r1);
    chk("periodic first irq delay", r1 - k, 32'd4);
    chk("periodic any1", 32'(any1), 32'h1);
    wr(0, 8'h0C, 32'h0);
    chk("periodic timint after clear", 32'(timint1[0]), 32'h0);
    wait_hi(0, 20, r2);
    chk("periodic irq interval", r2 - r1, 32'd4);
    wr(0, 8'h08, 32'h0);
    wr(0, 8'h0C, 32'h0);
    chk("ch0 stopped timint1", 32'(timint1), 32'h0);

    // One-shot ch1: LOAD=2, PRE=2 -> single interrupt 12 cycles after EN.
    wr(0, 8'h10, 32'd2);
    wr(0, 8'h18, 32'h207);
    k = cyc;
    wait_hi(1, 40, r1);
    chk("oneshot irq delay", r1 - k, 32'd12);
    rd(0, 8'h18, 32'h206, "oneshot ctrl EN cleared");
    rd(0, 8'h14, 32'h0, "oneshot value stays 0");
    wr(0, 8'h1C, 32'h0);
    cnt = 0;
    repeat (40) begin
      @(negedge PCLK);
      if (timint1[1]) cnt++;
    end
    chk("oneshot no further irq", cnt, 32'd0);

    // Collisions on ch2 (LOAD=3, PRE=0): zero ticks at r1, r1+4, r1+8, ...
    wr(0, 8'h20, 32'd3);
    wr(0, 8'h28, 32'h3);
    wait_hi(2, 20, r1);
    wr_at(0, 8'h2C, 32'h0, r1 + 4);
    chk("ris clear vs set collision", 32'(timint1[2]), 32'h1);
    wr_at(0, 8'h2C, 32'h0, r1 + 6);
    chk("ris clear ch2", 32'(timint1[2]), 32'h0);
    wr_at(0, 8'h20, 32'd10, r1 + 8);
    chk("load write on zero tick raw", 32'(timint1[2]), 32'h1);
    wr_at(0, 8'h28, 32'h2, r1 + 10);
    rd(0, 8'h24, 32'd9, "load reload then EN-off tick discarded");
    rd(0, 8'h20, 32'd10, "ch2 load after collision");
    wr(0, 8'h2C, 32'h0);

    // Reset while ch2 VALUE == 5.
    wr(0, 8'h20, 32'd20);
    L = cyc;
    wr(0, 8'h28, 32'h3);
    while (cyc < L + 17) @(negedge PCLK);
    rst1 = 1'b1;
    @(negedge PCLK);
    rst1 = 1'b0;
    chk("post-reset timint1", 32'(timint1), 32'h0);
    chk("post-reset any1", 32'(any1), 32'h0);
    rd(0, 8'h20, 32'h0, "post-reset ch2 load");
    rd(0, 8'h24, 32'h0, "post-reset ch2 value");
    rd(0, 8'h28, 32'h0, "post-reset ch2 ctrl");
    rd(0, 8'h00, 32'h0, "post-reset ch0 load");
    rd(0, 8'h30, 32'h0, "post-reset ch3 load");
    cnt = 0;
    repeat (40) begin
      @(negedge PCLK);
      if (any1) cnt++;
    end
    chk("post-reset no irq", cnt, 32'd0);
    rd(0, 8'h84, 32'h0, "post-reset ris_all");

    // Mask and active-low polarity on the second instance.
    wr(1, 8'h00, 32'd1);
    wr(1, 8'h08, 32'h1);
    repeat (4) @(negedge PCLK);
    rd(1, 8'h84, 32'h1, "masked ris_all");
    rd(1, 8'h80, 32'h0, "masked mis");
    chk("masked timint2", 32'(timint2), 32'h3);
    chk("masked any2", 32'(any2), 32'h1);
    wr(1, 8'h08, 32'h3);
    chk("unmasked timint2", 32'(timint2), 32'h2);
    chk("unmasked any2", 32'(any2), 32'h0);
    rd(1, 8'h80, 32'h1, "unmasked mis");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
